alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port round-robin arbiter and sequencer that shares one instance of the team's 32-bit combinational ALU between two requesters: requester 0 is the core execute stage and requester 1 is the coprocessor/debug path. Each request is a valid/ready transfer carrying the operands and a 4-bit ALU control code. The block registers the operands onto the ALU inputs and captures the ALU result and zero flag one cycle later. It returns them to the winning requester on a valid/ready response channel.

## Interface
- WIDTH, 32, operand/result width; must match the ALU instance.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- r0_req_valid, r1_req_valid  in  1  request present.
- r0_req_ready, r1_req_ready  out  1  request accepted this edge when ready and valid are both high.
- r0_req_a, r0_req_b, r1_req_a, r1_req_b  in  WIDTH  operands.
- r0_req_ctrl, r1_req_ctrl  in  4  ALU control code, forwarded unmodified; unused codes are legal and yield 0.
- r0_resp_valid, r1_resp_valid  out  1  response for that requester.
- r0_resp_ready, r1_resp_ready  in  1  response consumed.
- resp_result  out  WIDTH  result; shared by both response channels.
- resp_zero  out  1  zero flag; shared by both response channels.
- alu_a, alu_b  out  WIDTH  registered ALU operands.
- alu_ctrl  out  4  registered ALU control code.
- alu_out  in  WIDTH  ALU result.
- alu_zero  in  1  ALU zero flag.

## Operation
- The state machine has three states: IDLE, EXEC, RESP.
- An owner register (1 bit) records which requester is being served.
- A priority pointer prio (1 bit) names the requester that wins a tie.
- Accept condition (acc): state is IDLE, or state is RESP and the current owner's resp_ready is high.
- Grant (combinational, only when acc is true):
  - Only one valid: that requester wins.
  - Both valid: requester prio wins.
  - At most one req_ready is high in any cycle, and it is high only when that requester's valid is high.
- On an accepted request:
  - alu_a, alu_b and alu_ctrl load the winner's operands and control code.
  - owner takes the winner's index.
  - prio becomes the other requester.
  - The next state is EXEC.
- EXEC, always one cycle: resp_result and resp_zero capture alu_out and alu_zero. The next state is RESP.
- RESP:
  - The owner's resp_valid is high; the other requester's resp_valid is low.
  - The owner's resp_ready is high and a request is granted in the same cycle: go to EXEC with the new operands (back-to-back).
  - The owner's resp_ready is high and no request is granted: go to IDLE.
  - The owner's resp_ready is low: stay in RESP, with resp_result, resp_zero, owner and alu_* held stable.
- The non-owner's resp_ready is ignored.
- In IDLE with no request, alu_* hold their last values, resp_* hold their last values, and both resp_valid are low.
- reset value of every output and register:
  - alu_a = 0, alu_b = 0, alu_ctrl = 4'b0000.
  - resp_result = 0, resp_zero = 0.
  - Both resp_valid = 0 and both req_ready = 0 while reset is asserted.
  - state = IDLE, owner = 0, prio = 0.
- Reset asserted mid-operation (EXEC or RESP) aborts the operation. No response is delivered for it, and the request is not replayed.

## Timing
- Latency: a request accepted at edge T loads alu_* at T, captures the result at T+1, and resp_valid is high from T+1 until the edge where resp_ready is seen high.
- Peak throughput is one operation per 2 cycles (RESP→EXEC back-to-back). From IDLE, an operation occupies 3 cycles if resp_ready is already high.
- req_ready may depend combinationally on req_valid and resp_ready. resp_valid depends only on registered state.
- Requesters must hold req_a, req_b and req_ctrl stable while valid is high and ready is low.
- Starvation bound: a continuously valid requester is granted within 2 operations.

## Test plan
- Single op: r0 requests ADD, a=5, b=7 → r0_req_ready high in that cycle; r0_resp_valid high 1 edge later with resp_result=12, resp_zero=0; r1_resp_valid stays low.
- Tie rotation: both valid continuously from reset, r0 SUB 9-9, r1 OR 0xF0|0x0F, resp_ready tied high → grant order r0, r1, r0, r1; r0 responses give result 0 with zero=1; r1 responses give 0xFF with zero=0.
- Backpressure: r1 XOR 0xAAAA5555^0xFFFFFFFF with r1_resp_ready low for 3 cycles → resp_result=0x5555AAAA held constant, both req_ready low, r0 held off; r0 is granted in the cycle r1_resp_ready rises.
- Back-to-back: r0 SLT(-1,1) followed immediately by SLTU(-1,1) with resp_ready high → results 1 then 0 on consecutive responses, 2 cycles apart.
- Reset mid-op: assert reset during EXEC of an r0 ADD → all outputs immediately 0 or IDLE values, no r0_resp_valid after release, first tie after release goes to r0.
- Unused ctrl 4'b1000 with a=3, b=4 → resp_result=0, resp_zero=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two valid/ready requesters.
// Operands are registered onto the ALU, the result is captured a cycle later and returned to the winner.
//
// state | meaning
// IDLE  | no operation in flight; accepts a new request
// EXEC  | operands on the ALU; result captured at the end of this cycle
// RESP  | result presented to owner; may accept the next request when owner consumes
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r0_req_valid,
    output logic             r0_req_ready,
    input  logic [WIDTH-1:0] r0_req_a,
    input  logic [WIDTH-1:0] r0_req_b,
    input  logic [3:0]       r0_req_ctrl,
    input  logic             r1_req_valid,
    output logic             r1_req_ready,
    input  logic [WIDTH-1:0] r1_req_a,
    input  logic [WIDTH-1:0] r1_req_b,
    input  logic [3:0]       r1_req_ctrl,
    output logic             r0_resp_valid,
    input  logic             r0_resp_ready,
    output logic             r1_resp_valid,
    input  logic             r1_resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state, state_nxt;
    logic   owner;
    logic   prio;
    logic   owner_resp_ready;
    logic   acc;
    logic   gnt;
    logic   win;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        owner_resp_ready = owner ? r1_resp_ready : r0_resp_ready;
        // reset gates acceptance so no handshake is signalled while reset is held
        acc = !reset && ((state == IDLE) || (state == RESP && owner_resp_ready));
        gnt = acc && (r0_req_valid || r1_req_valid);
        win = 1'b0;
        if (r0_req_valid && r1_req_valid) win = prio;
        else if (r1_req_valid)            win = 1'b1;
        r0_req_ready = gnt && !win;
        r1_req_ready = gnt && win;

        state_nxt = state;
        case (state)
            IDLE:    if (gnt) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (owner_resp_ready) state_nxt = gnt ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctrl    <= 4'b0000;
            owner       <= 1'b0;
            prio        <= 1'b0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
        end else begin
            if (gnt) begin
                alu_a    <= win ? r1_req_a    : r0_req_a;
                alu_b    <= win ? r1_req_b    : r0_req_b;
                alu_ctrl <= win ? r1_req_ctrl : r0_req_ctrl;
                owner    <= win;
                prio     <= !win;
            end
            if (state == EXEC) begin
                resp_result <= alu_out;
                resp_zero   <= alu_zero;
            end
        end
    end

    assign r0_resp_valid = (state == RESP) && !owner;
    assign r1_resp_valid = (state == RESP) && owner;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, vector table, scoreboard of expected responses,
// and directed sequences for tie rotation, backpressure, back-to-back and mid-op reset.
module tb_alu_arbiter;

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011;
    localparam logic [3:0] C_SLTU = 4'b0100;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_NONE = 4'b1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_req_valid, r0_req_ready, r1_req_valid, r1_req_ready;
    logic [31:0] r0_req_a, r0_req_b, r1_req_a, r1_req_b;
    logic [3:0]  r0_req_ctrl, r1_req_ctrl;
    logic        r0_resp_valid, r0_resp_ready, r1_resp_valid, r1_resp_ready;
    logic [31:0] resp_result;
    logic        resp_zero;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_ctrl;
    logic        alu_zero;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        port;
        logic [31:0] res;
        logic        zero;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
    } vec_t;
    vec_t vecs[9];

    function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a,
                                              input logic [31:0] b);
        case (c)
            C_AND:   return a & b;
            C_OR:    return a | b;
            C_ADD:   return a + b;
            C_XOR:   return a ^ b;
            C_SLTU:  return {31'b0, (a < b)};
            C_SUB:   return a - b;
            C_SLT:   return {31'b0, ($signed(a) < $signed(b))};
            default: return 32'h0;
        endcase
    endfunction

    assign alu_out  = alu_model(alu_ctrl, alu_a, alu_b);
    assign alu_zero = (alu_out == 32'h0);

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
        .r0_req_a(r0_req_a), .r0_req_b(r0_req_b), .r0_req_ctrl(r0_req_ctrl),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
        .r1_req_a(r1_req_a), .r1_req_b(r1_req_b), .r1_req_ctrl(r1_req_ctrl),
        .r0_resp_valid(r0_resp_valid), .r0_resp_ready(r0_resp_ready),
        .r1_resp_valid(r1_resp_valid), .r1_resp_ready(r1_resp_ready),
        .resp_result(resp_result), .resp_zero(resp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: push on request handshake, pop on response handshake.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            check("ready_excl", {31'b0, r0_req_ready & r1_req_ready}, 32'h0);
            check("resp_valid_excl", {31'b0, r0_resp_valid & r1_resp_valid}, 32'h0);
            if ((r0_resp_valid && r0_resp_ready) || (r1_resp_valid && r1_resp_ready)) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_port", {31'b0, r1_resp_valid}, {31'b0, e.port});
                    check("sb_result", resp_result, e.res);
                    check("sb_zero", {31'b0, resp_zero}, {31'b0, e.zero});
                end
            end
            if (r0_req_valid && r0_req_ready)
                sb.push_back('{1'b0, alu_model(r0_req_ctrl, r0_req_a, r0_req_b),
                               alu_model(r0_req_ctrl, r0_req_a, r0_req_b) == 32'h0});
            if (r1_req_valid && r1_req_ready)
                sb.push_back('{1'b1, alu_model(r1_req_ctrl, r1_req_a, r1_req_b),
                               alu_model(r1_req_ctrl, r1_req_a, r1_req_b) == 32'h0});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic port);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (port ? r1_req_ready : r0_req_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("req_timeout", {31'b0, got}, 32'h1);
    endtask

    task automatic wait_resp(input logic port);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (port ? r1_resp_valid : r0_resp_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("resp_timeout", {31'b0, got}, 32'h1);
    endtask

    task automatic set_r0(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        r0_req_ctrl = c;
        r0_req_a    = a;
        r0_req_b    = b;
    endtask

    task automatic set_r1(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        r1_req_ctrl = c;
        r1_req_a    = a;
        r1_req_b    = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{C_ADD,  32'd5,        32'd7,        32'd12,       1'b0};
        vecs[1] = '{C_SUB,  32'd9,        32'd9,        32'd0,        1'b1};
        vecs[2] = '{C_OR,   32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0};
        vecs[3] = '{C_XOR,  32'hAAAA5555, 32'hFFFFFFFF, 32'h5555AAAA, 1'b0};
        vecs[4] = '{C_SLT,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
        vecs[5] = '{C_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
        vecs[6] = '{C_NONE, 32'd3,        32'd4,        32'd0,        1'b1};
        vecs[7] = '{C_AND,  32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1'b0};
        vecs[8] = '{C_ADD,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};

        reset = 1'b1;
        r0_req_valid = 1'b0; r1_req_valid = 1'b0;
        r0_resp_ready = 1'b1; r1_resp_ready = 1'b1;
        set_r0(C_ADD, 32'd0, 32'd0);
        set_r1(C_ADD, 32'd0, 32'd0);

        // reset values, req_ready suppressed while reset held
        #1;
        r0_req_valid = 1'b1;
        r1_req_valid = 1'b1;
        #1;
        check("rst_r0_req_ready", {31'b0, r0_req_ready}, 32'h0);
        check("rst_r1_req_ready", {31'b0, r1_req_ready}, 32'h0);
        check("rst_alu_a", alu_a, 32'h0);
        check("rst_alu_b", alu_b, 32'h0);
        check("rst_alu_ctrl", {28'b0, alu_ctrl}, 32'h0);
        check("rst_resp_result", resp_result, 32'h0);
        check("rst_resp_zero", {31'b0, resp_zero}, 32'h0);
        check("rst_resp_valid", {30'b0, r1_resp_valid, r0_resp_valid}, 32'h0);
        r0_req_valid = 1'b0;
        r1_req_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // single op with exact latency
        set_r0(C_ADD, 32'd5, 32'd7);
        r0_req_valid = 1'b1;
        @(negedge clk);
        check("single_r0_ready", {31'b0, r0_req_ready}, 32'h1);
        check("single_r1_ready", {31'b0, r1_req_ready}, 32'h0);
        tick();
        r0_req_valid = 1'b0;
        check("single_alu_a", alu_a, 32'd5);
        check("single_alu_b", alu_b, 32'd7);
        check("single_alu_ctrl", {28'b0, alu_ctrl}, {28'b0, C_ADD});
        check("single_exec_valid", {31'b0, r0_resp_valid}, 32'h0);
        tick();
        check("single_resp_valid", {31'b0, r0_resp_valid}, 32'h1);
        check("single_result", resp_result, 32'd12);
        check("single_zero", {31'b0, resp_zero}, 32'h0);
        check("single_r1_resp", {31'b0, r1_resp_valid}, 32'h0);
        tick();
        check("single_idle_valid", {31'b0, r0_resp_valid}, 32'h0);

        // vector table through r0
        for (int i = 0; i < 9; i++) begin
            set_r0(vecs[i].ctrl, vecs[i].a, vecs[i].b);
            r0_req_valid = 1'b1;
            wait_req(1'b0);
            tick();
            r0_req_valid = 1'b0;
            wait_resp(1'b0);
            check("vec_result", resp_result, vecs[i].res);
            check("vec_zero", {31'b0, resp_zero}, {31'b0, vecs[i].zero});
            tick();
        end

        // tie rotation from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_r0(C_SUB, 32'd9, 32'd9);
        set_r1(C_OR, 32'h000000F0, 32'h0000000F);
        r0_req_valid = 1'b1;
        r1_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic got;
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (r0_req_ready || r1_req_ready) begin
                    got = 1'b1;
                    break;
                end
            end
            check("tie_timeout", {31'b0, got}, 32'h1);
            check("tie_grant", {31'b0, r1_req_ready}, k % 2);
            tick();
        end
        r0_req_valid = 1'b0;
        r1_req_valid = 1'b0;
        repeat (3) tick();

        // backpressure on r1, r0 waiting, non-owner resp_ready high
        set_r1(C_XOR, 32'hAAAA5555, 32'hFFFFFFFF);
        r1_resp_ready = 1'b0;
        r0_resp_ready = 1'b1;
        r1_req_valid  = 1'b1;
        wait_req(1'b1);
        tick();
        r1_req_valid = 1'b0;
        set_r0(C_ADD, 32'd1, 32'd2);
        r0_req_valid = 1'b1;
        tick();
        repeat (3) begin
            @(negedge clk);
            check("bp_result", resp_result, 32'h5555AAAA);
            check("bp_zero", {31'b0, resp_zero}, 32'h0);
            check("bp_alu_a", alu_a, 32'hAAAA5555);
            check("bp_r1_valid", {31'b0, r1_resp_valid}, 32'h1);
            check("bp_r0_valid", {31'b0, r0_resp_valid}, 32'h0);
            check("bp_req_ready", {30'b0, r1_req_ready, r0_req_ready}, 32'h0);
            tick();
        end
        r1_resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_grant", {31'b0, r0_req_ready}, 32'h1);
        tick();
        r0_req_valid = 1'b0;
        repeat (3) tick();

        // back-to-back SLT then SLTU on r0
        set_r0(C_SLT, 32'hFFFFFFFF, 32'd1);
        r0_req_valid = 1'b1;
        wait_req(1'b0);
        tick();
        r0_req_ctrl = C_SLTU;
        @(negedge clk);
        check("b2b_exec_ready", {31'b0, r0_req_ready}, 32'h0);
        tick();
        @(negedge clk);
        check("b2b_regrant", {31'b0, r0_req_ready}, 32'h1);
        check("b2b_first_valid", {31'b0, r0_resp_valid}, 32'h1);
        check("b2b_first_result", resp_result, 32'd1);
        tick();
        r0_req_valid = 1'b0;
        tick();
        @(negedge clk);
        check("b2b_second_valid", {31'b0, r0_resp_valid}, 32'h1);
        check("b2b_second_result", resp_result, 32'd0);
        check("b2b_second_zero", {31'b0, resp_zero}, 32'h1);
        tick();
        tick();

        // reset during EXEC; prio was moved to r1 by the r0 ops above
        set_r0(C_ADD, 32'd10, 32'd20);
        r0_req_valid = 1'b1;
        wait_req(1'b0);
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_alu_a", alu_a, 32'h0);
        check("mid_rst_alu_b", alu_b, 32'h0);
        check("mid_rst_alu_ctrl", {28'b0, alu_ctrl}, 32'h0);
        check("mid_rst_result", resp_result, 32'h0);
        check("mid_rst_zero", {31'b0, resp_zero}, 32'h0);
        check("mid_rst_req_ready", {31'b0, r0_req_ready}, 32'h0);
        r0_req_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        set_r1(C_OR, 32'h000000F0, 32'h0000000F);
        r0_req_valid = 1'b1;
        r1_req_valid = 1'b1;
        @(negedge clk);
        check("post_rst_r0_grant", {31'b0, r0_req_ready}, 32'h1);
        check("post_rst_r1_grant", {31'b0, r1_req_ready}, 32'h0);
        check("post_rst_no_resp", {30'b0, r1_resp_valid, r0_resp_valid}, 32'h0);
        tick();
        r0_req_valid = 1'b0;
        r1_req_valid = 1'b0;
        repeat (4) tick();

        check("sb_empty", sb.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
